// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard detection and operand-forwarding control for a 5-stage core.
// Optional feature macro: HAZ_FWD_EN (defined: EX/MEM forwarding; undefined: stall on every RAW match).
module hazard_fwd_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic        id_valid,
  input  logic [2:0]  ex_wreg,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_valid,
  input  logic        branch_taken,
  input  logic        mem_stall,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic        stall_fetch,
  output logic        bubble_ex,
  output logic        flush_if_id,
  output logic        freeze_all,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    FREEZE  = 2'b01,
    LUSTALL = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  mem_wreg_r;
  logic        mem_rw_r;
  logic [2:0]  wb_wreg_r;
  logic        wb_rw_r;
  logic        ex_bubble_r;
  logic [1:0]  fwd_a_r;
  logic [1:0]  fwd_b_r;
  logic [15:0] stall_cnt_r;

  logic        ex_live_s;
  logic        ex_wr_s;
  logic        ex_hit_s;
  logic        mem_hit_s;
  logic        wb_hit_s;
  logic        lu_s;
  logic        stall_fetch_s;
  logic        bubble_ex_s;
  logic        flush_if_id_s;
  logic        freeze_all_s;

  function automatic logic src_hit(input logic used, input logic [2:0] src,
                                   input logic [2:0] dst);
    return used & (src == dst);
  endfunction

`ifdef HAZ_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic used, input logic [2:0] src,
                                         input logic ex_wr, input logic [2:0] ex_dst,
                                         input logic mem_wr, input logic [2:0] mem_dst);
    if (ex_wr & src_hit(used, src, ex_dst)) begin
      return 2'b10;
    end else if (mem_wr & src_hit(used, src, mem_dst)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction
`endif

  // RAW match detection against the EX, MEM and WB destinations
  always_comb begin
    ex_live_s = ex_valid & ~ex_bubble_r;
    ex_wr_s   = ex_regwrite & ex_live_s;
    ex_hit_s  = ex_wr_s  & (src_hit(id_rs_used, id_rs, ex_wreg) |
                            src_hit(id_rt_used, id_rt, ex_wreg));
    mem_hit_s = mem_rw_r & (src_hit(id_rs_used, id_rs, mem_wreg_r) |
                            src_hit(id_rt_used, id_rt, mem_wreg_r));
    wb_hit_s  = wb_rw_r  & (src_hit(id_rs_used, id_rs, wb_wreg_r) |
                            src_hit(id_rt_used, id_rt, wb_wreg_r));
`ifdef HAZ_FWD_EN
    lu_s = id_valid & ex_memread & ex_hit_s;
`else
    // Without forwarding a load and an ALU result must both reach the register file first
    lu_s = id_valid & ((ex_memread & ex_hit_s) | ex_hit_s | mem_hit_s | wb_hit_s);
`endif
  end

  // Pipeline control with priority freeze > branch > load-use
  always_comb begin
    stall_fetch_s = 1'b0;
    bubble_ex_s   = 1'b0;
    flush_if_id_s = 1'b0;
    freeze_all_s  = 1'b0;
    if (!rst) begin
      stall_fetch_s = 1'b0;
    end else if (mem_stall) begin
      freeze_all_s  = 1'b1;
      stall_fetch_s = 1'b1;
    end else if (branch_taken) begin
      flush_if_id_s = 1'b1;
      bubble_ex_s   = 1'b1;
    end else if (lu_s) begin
      stall_fetch_s = 1'b1;
      bubble_ex_s   = 1'b1;
    end else begin
      stall_fetch_s = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (mem_stall) begin
          state_nxt_s = FREEZE;
        end else if (!branch_taken && lu_s) begin
          state_nxt_s = LUSTALL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FREEZE: begin
        if (mem_stall) begin
          state_nxt_s = FREEZE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      LUSTALL: begin
        if (mem_stall) begin
          state_nxt_s = FREEZE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // MEM/WB destination tracking; ex_bubble_r marks a NOP sitting in EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wreg_r  <= 3'd0;
      mem_rw_r    <= 1'b0;
      wb_wreg_r   <= 3'd0;
      wb_rw_r     <= 1'b0;
      ex_bubble_r <= 1'b0;
    end else if (!freeze_all_s) begin
      mem_wreg_r  <= ex_wreg;
      mem_rw_r    <= ex_wr_s;
      wb_wreg_r   <= mem_wreg_r;
      wb_rw_r     <= mem_rw_r;
      ex_bubble_r <= bubble_ex_s;
    end
  end

  // Forward selects, one cycle ahead of their use in EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end else if (freeze_all_s) begin
      fwd_a_r <= fwd_a_r;
      fwd_b_r <= fwd_b_r;
    end else if (bubble_ex_s) begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end else begin
`ifdef HAZ_FWD_EN
      fwd_a_r <= fwd_sel(id_rs_used, id_rs, ex_wr_s, ex_wreg, mem_rw_r, mem_wreg_r);
      fwd_b_r <= fwd_sel(id_rt_used, id_rt, ex_wr_s, ex_wreg, mem_rw_r, mem_wreg_r);
`else
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
`endif
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_fetch_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign forwardA    = fwd_a_r;
  assign forwardB    = fwd_b_r;
  assign stall_fetch = stall_fetch_s;
  assign bubble_ex   = bubble_ex_s;
  assign flush_if_id = flush_if_id_s;
  assign freeze_all  = freeze_all_s;
  assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed self-checking bench for hazard_fwd_ctrl; expectations follow HAZ_FWD_EN.
module tb_hazard_fwd_ctrl;

`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  id_rs, id_rt, ex_wreg;
  logic        id_rs_used, id_rt_used, id_valid;
  logic        ex_regwrite, ex_memread, ex_valid, branch_taken, mem_stall;
  logic [1:0]  forwardA, forwardB;
  logic        stall_fetch, bubble_ex, flush_if_id, freeze_all;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  hazard_fwd_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_valid(id_valid), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_valid(ex_valid), .branch_taken(branch_taken),
    .mem_stall(mem_stall), .forwardA(forwardA), .forwardB(forwardB),
    .stall_fetch(stall_fetch), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
    .freeze_all(freeze_all), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctrl(input string tag, input logic s, input logic b, input logic f, input logic z);
    chk({tag, "_stall"}, {15'd0, stall_fetch}, {15'd0, s});
    chk({tag, "_bubble"}, {15'd0, bubble_ex}, {15'd0, b});
    chk({tag, "_flush"}, {15'd0, flush_if_id}, {15'd0, f});
    chk({tag, "_freeze"}, {15'd0, freeze_all}, {15'd0, z});
  endtask

  task automatic fwd_chk(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk({tag, "_fwdA"}, {14'd0, forwardA}, {14'd0, a});
    chk({tag, "_fwdB"}, {14'd0, forwardB}, {14'd0, b});
  endtask

  task automatic idle();
    id_rs = 3'd0; id_rt = 3'd0; id_rs_used = 1'b0; id_rt_used = 1'b0; id_valid = 1'b0;
    ex_wreg = 3'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_valid = 1'b0;
    branch_taken = 1'b0; mem_stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    int n;
    idle();
    rst = 1'b0;
    #2;
    ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    fwd_chk("reset", 2'b00, 2'b00);
    chk("reset_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // ADD r3 in EX, ID reads r3 as rs
    ex_wreg = 3'd3; ex_regwrite = 1'b1; ex_valid = 1'b1;
    id_rs = 3'd3; id_rs_used = 1'b1; id_rt = 3'd5; id_rt_used = 1'b1; id_valid = 1'b1;
    #1 ctrl("add_ex", !FWD, !FWD, 1'b0, 1'b0);
    step(); exp_cnt += !FWD;
    fwd_chk("add_ex", FWD ? 2'b10 : 2'b00, 2'b00);
    chk("add_ex_cnt", stall_cnt, exp_cnt[15:0]);
    drain();

    // LD r2 in EX, ID reads r2 as rt; then the bubble sits in EX
    ex_wreg = 3'd2; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_valid = 1'b1;
    id_rs = 3'd1; id_rs_used = 1'b1; id_rt = 3'd2; id_rt_used = 1'b1; id_valid = 1'b1;
    #1 ctrl("ld_use", 1'b1, 1'b1, 1'b0, 1'b0);
    step(); exp_cnt += 1;
    fwd_chk("ld_use", 2'b00, 2'b00);
    ex_wreg = 3'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_valid = 1'b0;
    #1 ctrl("ld_re1", !FWD, !FWD, 1'b0, 1'b0);
    step(); exp_cnt += !FWD;
    fwd_chk("ld_re1", 2'b00, FWD ? 2'b01 : 2'b00);
    #1 ctrl("ld_re2", !FWD, !FWD, 1'b0, 1'b0);
    step(); exp_cnt += !FWD;
    #1 ctrl("ld_re3", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("ld_cnt", stall_cnt, exp_cnt[15:0]);
    drain();

    // branch taken together with a load-use hazard
    ex_wreg = 3'd4; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_valid = 1'b1;
    id_rs = 3'd4; id_rs_used = 1'b1; id_valid = 1'b1; branch_taken = 1'b1;
    #1 ctrl("br_lu", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    fwd_chk("br_lu", 2'b00, 2'b00);
    chk("br_lu_cnt", stall_cnt, exp_cnt[15:0]);
    drain();

    // ADD hazard pending across a 3-cycle memory freeze
    ex_wreg = 3'd6; ex_regwrite = 1'b1; ex_valid = 1'b1;
    id_rs = 3'd6; id_rs_used = 1'b1; id_rt = 3'd7; id_rt_used = 1'b1; id_valid = 1'b1;
    #1 ctrl("pre_frz", !FWD, !FWD, 1'b0, 1'b0);
    step(); exp_cnt += !FWD;
    fwd_chk("pre_frz", FWD ? 2'b10 : 2'b00, 2'b00);
    ex_wreg = 3'd7; mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 ctrl("frz", 1'b1, 1'b0, 1'b0, 1'b1);
      step(); exp_cnt += 1;
      fwd_chk("frz_hold", FWD ? 2'b10 : 2'b00, 2'b00);
    end
    chk("frz_cnt", stall_cnt, exp_cnt[15:0]);
    mem_stall = 1'b0;
    #1 ctrl("frz_rel", !FWD, !FWD, 1'b0, 1'b0);
    step(); exp_cnt += !FWD;
    fwd_chk("frz_rel", FWD ? 2'b01 : 2'b00, FWD ? 2'b10 : 2'b00);
    drain();

    // branch held during a freeze is acted on after release
    mem_stall = 1'b1; branch_taken = 1'b1;
    #1 ctrl("br_frz", 1'b1, 1'b0, 1'b0, 1'b1);
    step(); exp_cnt += 1;
    mem_stall = 1'b0;
    #1 ctrl("br_rel", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk("br_frz_cnt", stall_cnt, exp_cnt[15:0]);
    drain();

    // counter saturation
    n = 32'hFFFE - exp_cnt;
    mem_stall = 1'b1;
    repeat (n) step();
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    repeat (4) step();
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    drain();

    // reset asserted in the middle of a load-use stall
    ex_wreg = 3'd2; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_valid = 1'b1;
    id_rt = 3'd2; id_rt_used = 1'b1; id_valid = 1'b1;
    #1 ctrl("lus0", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    ex_wreg = 3'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_valid = 1'b0;
    #1 ctrl("lus1", !FWD, !FWD, 1'b0, 1'b0);
    step();
    fwd_chk("lus1", 2'b00, FWD ? 2'b01 : 2'b00);
    chk("lus1_cnt", stall_cnt, 16'hFFFF);
    #1 ctrl("lus2", !FWD, !FWD, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    ctrl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    fwd_chk("rst_mid", 2'b00, 2'b00);
    chk("rst_mid_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 ctrl("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    fwd_chk("post_rst", 2'b00, 2'b00);
    chk("post_rst_cnt", stall_cnt, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
